// File: rtl/wb_regfile_if.sv
// wb_regfile_if: bundle of the MEM/WB write-back signals and the ID-stage
// read ports that connect to the wb_regfile block.
//   WB[1:0]      RegWrite (bit 1) / MemtoReg (bit 0) from MEM/WB
//   ALU_Result   ALU result from MEM/WB
//   MemReadData  load data from MEM/WB
//   RdAddr       destination register index
//   RsAddr/RtAddr  ID-stage read indices
//   RsData/RtData  ID-stage read data
//   WriteData    selected write-back value (to forwarding unit)
//   RegWrite_out effective write enable (to forwarding unit)
// Modports: slave = register file side, master = pipeline/driver side.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [1:0]        WB;
  logic [DATA_W-1:0] ALU_Result;
  logic [DATA_W-1:0] MemReadData;
  logic [ADDR_W-1:0] RdAddr;
  logic [ADDR_W-1:0] RsAddr;
  logic [ADDR_W-1:0] RtAddr;
  logic [DATA_W-1:0] RsData;
  logic [DATA_W-1:0] RtData;
  logic [DATA_W-1:0] WriteData;
  logic              RegWrite_out;

  modport slave (
    input  WB, ALU_Result, MemReadData, RdAddr, RsAddr, RtAddr,
    output RsData, RtData, WriteData, RegWrite_out
  );

  modport master (
    output WB, ALU_Result, MemReadData, RdAddr, RsAddr, RtAddr,
    input  RsData, RtData, WriteData, RegWrite_out
  );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: write-back select plus the 32x32 general-purpose register file.
// Selects the write-back value from MEM/WB, commits it on posedge clk, and
// serves two asynchronous read ports for the ID stage. $0 reads as zero and
// is never written.
// Ports:
//   clk  - single clock, all state updates on posedge
//   rst  - synchronous active-high reset, clears every register
//   bus  - wb_regfile_if.slave (write-back inputs, read ports, forwarding outputs)
// Optional feature macro: RF_BYPASS_EN
//   defined   - a read of the register being written this cycle returns
//               the new WriteData (write-before-read)
//   undefined - reads always return stored contents (old value)
module wb_regfile #(
  parameter int REG_COUNT = 32,
  parameter int DATA_W    = 32
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);

  localparam int ADDR_W = $clog2(REG_COUNT);

  logic [DATA_W-1:0] regs [REG_COUNT];
  logic [DATA_W-1:0] wdata;
  logic              reg_we;

  // Read-port mux: $0 forced to zero regardless of storage; optional
  // same-cycle bypass of the value being committed.
  function automatic logic [DATA_W-1:0] read_sel(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              we,
    input logic [ADDR_W-1:0] rd,
    input logic [DATA_W-1:0] wd
  );
    logic [DATA_W-1:0] val;
    val = stored;
`ifdef RF_BYPASS_EN
    if (we && (addr == rd)) val = wd;
`else
    if (we && (addr == rd)) val = stored;
`endif
    if (addr == '0) val = '0;
    return val;
  endfunction

  always_comb begin
    wdata  = bus.WB[0] ? bus.MemReadData : bus.ALU_Result;
    // Masking with ~rst keeps the forwarding unit from seeing a write that
    // reset is about to discard.
    reg_we = bus.WB[1] & (bus.RdAddr != '0) & ~rst;
  end

  assign bus.WriteData    = wdata;
  assign bus.RegWrite_out = reg_we;

  always_comb begin
    bus.RsData = read_sel(bus.RsAddr, regs[bus.RsAddr], reg_we, bus.RdAddr, wdata);
    bus.RtData = read_sel(bus.RtAddr, regs[bus.RtAddr], reg_we, bus.RdAddr, wdata);
  end

  // Commit stage: reset wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[bus.RdAddr] <= wdata;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  logic clk;
  logic rst;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_regfile #(.REG_COUNT(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    int          id;
    bit          chk_rd;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] wd;
    logic        we;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [32];
  int          tests = 0;
  int          fails = 0;
  int          txn   = 0;

  // Architectural reference: what a read of 'a' must return this cycle.
  function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] rd, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
    if (BYPASS && we && a == rd) return wd;
    return model[a];
  endfunction

  // Drive one cycle of stimulus, predict outputs, then advance the model
  // by the edge that ends the cycle.
  task automatic do_cycle(input logic r, input logic [1:0] wb, input logic [31:0] alu,
                          input logic [31:0] mem, input logic [4:0] rd,
                          input logic [4:0] rs, input logic [4:0] rt, input bit chk_rd);
    exp_t        e;
    logic [31:0] wd;
    logic        we;
    @(posedge clk);
    #1;
    rst             = r;
    bus.WB          = wb;
    bus.ALU_Result  = alu;
    bus.MemReadData = mem;
    bus.RdAddr      = rd;
    bus.RsAddr      = rs;
    bus.RtAddr      = rt;
    wd = wb[0] ? mem : alu;
    we = wb[1] && (rd != 5'd0) && !r;
    e.id     = txn;
    e.chk_rd = chk_rd;
    e.wd     = wd;
    e.we     = we;
    e.rs     = ref_read(rs, we, rd, wd);
    e.rt     = ref_read(rt, we, rd, wd);
    exp_q.push_back(e);
    txn++;
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (we) begin
      model[rd] = wd;
    end
  endtask

  // Monitor: outputs are combinational and valid every cycle; sample at negedge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (bus.WriteData !== e.wd) begin
        fails++;
        $display("FAIL WriteData txn=%0d got=%h exp=%h", e.id, bus.WriteData, e.wd);
      end
      tests++;
      if (bus.RegWrite_out !== e.we) begin
        fails++;
        $display("FAIL RegWrite_out txn=%0d got=%b exp=%b", e.id, bus.RegWrite_out, e.we);
      end
      if (e.chk_rd) begin
        tests++;
        if (bus.RsData !== e.rs) begin
          fails++;
          $display("FAIL RsData txn=%0d addr=%0d got=%h exp=%h", e.id, bus.RsAddr, bus.RsData, e.rs);
        end
        tests++;
        if (bus.RtData !== e.rt) begin
          fails++;
          $display("FAIL RtData txn=%0d addr=%0d got=%h exp=%h", e.id, bus.RtAddr, bus.RtData, e.rt);
        end
      end
    end
  end

  initial begin
    logic [4:0] rd, rs, rt;
    rst = 1'b1;
    bus.WB = 2'b00; bus.ALU_Result = '0; bus.MemReadData = '0;
    bus.RdAddr = '0; bus.RsAddr = '0; bus.RtAddr = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // Power-up reset: storage unknown during this cycle, skip read checks.
    do_cycle(1, 2'b10, 32'h1, 32'h2, 5'd4, 5'd5, 5'd4, 0);
    do_cycle(0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0, 1);

    // Reset clears a preloaded value; write during reset is discarded.
    do_cycle(0, 2'b10, 32'hDEADBEEF, 32'h0, 5'd5, 5'd5, 5'd5, 1);
    do_cycle(1, 2'b10, 32'h00000077, 32'h0, 5'd4, 5'd5, 5'd4, 1);
    do_cycle(0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd5, 5'd4, 1);

    // ALU and load write-back.
    do_cycle(0, 2'b10, 32'h00000011, 32'hAAAA5555, 5'd8, 5'd1, 5'd2, 1);
    do_cycle(0, 2'b11, 32'h00001234, 32'hCAFEF00D, 5'd9, 5'd0, 5'd8, 1);
    do_cycle(0, 2'b01, 32'h00005678, 32'h12345678, 5'd9, 5'd9, 5'd8, 1);

    // $0 protection.
    do_cycle(0, 2'b10, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd0, 5'd9, 1);
    do_cycle(0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1);

    // Same-cycle read/write of $3, both ports on the same register.
    do_cycle(0, 2'b10, 32'h1, 32'h0, 5'd3, 5'd0, 5'd0, 1);
    do_cycle(0, 2'b10, 32'h2, 32'h0, 5'd3, 5'd3, 5'd3, 1);
    do_cycle(0, 2'b00, 32'h0, 32'h0, 5'd0, 5'd3, 5'd3, 1);

    // Randomized traffic with biased address collisions and rare resets.
    for (int n = 0; n < 600; n++) begin
      rd = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) rd = 5'd0;
      rs = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rt = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      do_cycle(($urandom_range(0, 49) == 0), 2'($urandom), $urandom, $urandom,
               rd, rs, rt, 1);
    end

    // Bounded drain of the scoreboard.
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and general-purpose register file of the 5-stage pipeline. It consumes the MEM/WB pipeline register outputs (`WB`, `ALU_Result`, `MemReadData`, `RdAddr`) and selects the write-back value. It commits that value into a 32×32-bit register file on the clock edge. It also serves the two decode-stage read ports (rs, rt), with optional same-cycle write-through bypass.

## Interface
Parameters:
- `REG_COUNT`, 32: number of architectural registers. Fixed by the ISA; not to be overridden.
- `DATA_W`, 32: register and data width.

Ports:
- `clk`, input, 1: the single clock. All state updates on posedge.
- `rst`, input, 1: synchronous, active-high reset, sampled on posedge `clk`.
- `WB`, input, 2: write-back control from MEM/WB. `WB[1]` = RegWrite, `WB[0]` = MemtoReg.
- `ALU_Result`, input, 32: ALU result from MEM/WB.
- `MemReadData`, input, 32: load data from MEM/WB.
- `RdAddr`, input, 5: destination register index from MEM/WB.
- `RsAddr`, input, 5: read port A index, from the ID stage.
- `RtAddr`, input, 5: read port B index, from the ID stage.
- `RsData`, output, 32: read port A data.
- `RtData`, output, 32: read port B data.
- `WriteData`, output, 32: selected write-back value, consumed by the forwarding unit.
- `RegWrite_out`, output, 1: effective write enable, consumed by the forwarding unit.

## Operation
- Write-back select is combinational:
  - `WriteData = WB[0] ? MemReadData : ALU_Result`.
- Effective write enable is combinational:
  - `RegWrite_out = WB[1] & (RdAddr != 0) & ~rst`.
- Register array: `regs[0..31]`, each 32 bits.
  - On posedge `clk` with `rst` = 1, all 32 entries are cleared to 0. Reset has priority over any write in the same cycle.
  - On posedge `clk` with `rst` = 0 and `RegWrite_out` = 1, `regs[RdAddr] <= WriteData`.
  - Otherwise the array holds its value.
- `$0` is hardwired to zero:
  - Writes to index 0 are dropped.
  - Reads of index 0 always return 0, independent of storage contents.
- Read ports are asynchronous (combinational) on `RsAddr` and `RtAddr`.
  - Base behaviour: `RsData = regs[RsAddr]`, `RtData = regs[RtAddr]`.
  - Bypass override when `RF_BYPASS_EN` is defined: see Configuration.
- Both read ports may address the same register, and both return the same value.
- A single write port is used. There is no write-write conflict.
- Block state is the register array only. The block has no handshake, and the pipeline advances every cycle.

## Timing
- Reset values:
  - All `regs` = 0 after the first posedge with `rst` = 1.
  - `RsData` and `RtData` read 0 for every index after that edge.
  - `RegWrite_out` = 0 while `rst` is high.
  - `WriteData` follows its inputs combinationally; it has no reset value.
- Write latency: one edge. A value presented in cycle N is stored at the posedge ending cycle N and is readable from the array in cycle N+1.
- Read latency: zero cycles. Outputs follow the address inputs combinationally.
- Reset asserted mid-stream: a pending write in that cycle is discarded. The first write after reset is the one presented in the first cycle with `rst` = 0.
- The block ignores `WB[0]` when `WB[1]` = 0. No write occurs, and `WriteData` is still driven.

## Configuration
- Macro: `RF_BYPASS_EN`.
- Defined:
  - When `RegWrite_out` = 1 and `RsAddr == RdAddr`, `RsData = WriteData` in the same cycle. The same rule applies to `RtData` and `RtAddr`.
  - This gives write-before-read semantics, so the ID stage needs no separate WB→ID forward.
  - Index 0 is never bypassed.
- Not defined:
  - Reads always return array contents.
  - A same-cycle read of the register being written returns the old value. The new value is visible in cycle N+1.
  - Hazard handling is then the responsibility of the hazard unit.

## Test plan
- Reset: preload `regs[5]` = 0xDEADBEEF. Assert `rst` for one edge → `RsAddr` = 5 reads 0x00000000, and `RegWrite_out` = 0 while `rst` = 1.
- ALU write-back: `WB` = 2'b10, `ALU_Result` = 0x00000011, `RdAddr` = 8, one edge → `RtAddr` = 8 reads 0x00000011.
- Load write-back: `WB` = 2'b11, `MemReadData` = 0xCAFEF00D, `ALU_Result` = 0x00001234, `RdAddr` = 9 → `WriteData` = 0xCAFEF00D, and after the edge `regs[9]` = 0xCAFEF00D.
- `$0` protection: `WB` = 2'b10, `RdAddr` = 0, `ALU_Result` = 0xFFFFFFFF → `RegWrite_out` = 0, and `RsAddr` = 0 reads 0 after the edge.
- Same-cycle read/write: `regs[3]` = 0x1, write 0x2 to `RdAddr` = 3 with `RsAddr` = 3 in the same cycle:
  - With `RF_BYPASS_EN`, `RsData` = 0x2 before the edge.
  - Without it, `RsData` = 0x1 before the edge and 0x2 after.
- Reset priority: `rst` = 1 together with `WB` = 2'b10, `RdAddr` = 4, `ALU_Result` = 0x77 → `regs[4]` = 0 after the edge.
